// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and execute-side bus of the decode queue.
//   Fetch side  : inValid/inReady handshake, inInstruction (raw), inPC.
//   Execute side: outValid/outReady handshake, outPC, decoded fields
//                 (opcode, rd, fun3, rs1, rs2, fun7), immediateValue, opALU
//                 and the per-instruction control flags.
// master modport is the fetch/execute environment, slave is the queue.
interface decode_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            inValid;
  logic            inReady;
  logic [31:0]     inInstruction;
  logic [XLEN-1:0] inPC;

  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] outPC;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      fun3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      fun7;
  logic [XLEN-1:0] immediateValue;
  logic [3:0]      opALU;
  logic            enRegWrite;
  logic            enALU;
  logic            useImmediate;
  logic            isBranch;
  logic            isJump;
  logic            isLoad;
  logic            isStore;
  logic            isVI;
  logic            isIllegal;

  modport master (
    output inValid, inInstruction, inPC, outReady,
    input  inReady, outValid, outPC, opcode, rd, fun3, rs1, rs2, fun7,
    input  immediateValue, opALU, enRegWrite, enALU, useImmediate,
    input  isBranch, isJump, isLoad, isStore, isVI, isIllegal
  );

  modport slave (
    input  inValid, inInstruction, inPC, outReady,
    output inReady, outValid, outPC, opcode, rd, fun3, rs1, rs2, fun7,
    output immediateValue, opALU, enRegWrite, enALU, useImmediate,
    output isBranch, isJump, isLoad, isStore, isVI, isIllegal
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: buffered RV32I/RV64I decode stage between fetch and execute.
// Instructions are decoded combinationally on entry and the decoded bundle is
// stored in a DEPTH-entry FIFO; execute sees the head slot directly.
// Ports:
//   clk          - clock, all state on rising edge
//   rstN         - asynchronous active-low reset
//   flush        - synchronous discard of all queued entries
//   bus          - decode_queue_if.slave (fetch and execute handshakes)
//   count        - occupied entries
//   illegalCount - saturating count of accepted illegal instructions
module decode_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   flush,
  decode_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNTW-1:0]        illegalCount
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluXor   = 4'b0100;
  localparam logic [3:0] AluSlt   = 4'b0101;
  localparam logic [3:0] AluSltu  = 4'b0110;
  localparam logic [3:0] AluSll   = 4'b0111;
  localparam logic [3:0] AluSrl   = 4'b1000;
  localparam logic [3:0] AluSra   = 4'b1001;
  localparam logic [3:0] AluPassB = 4'b1010;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      fun3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      fun7;
    logic [3:0]      alu;
    logic            reg_write;
    logic            en_alu;
    logic            use_imm;
    logic            branch;
    logic            jump;
    logic            load;
    logic            store;
    logic            vi;
    logic            illegal;
  } bundle_t;

  bundle_t         r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [CNTW-1:0] r_illegal_cnt;

  logic [31:0]     w_ins;
  logic [2:0]      w_fun3;
  logic [6:0]      w_fun7;
  logic            w_shamt_ok;
  logic            w_illegal;
  logic [3:0]      w_alu;
  logic [XLEN-1:0] w_imm;
  logic            w_reg_write;
  logic            w_en_alu;
  logic            w_use_imm;
  logic            w_branch;
  logic            w_jump;
  logic            w_load;
  logic            w_store;
  bundle_t         w_dec;
  bundle_t         w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_ready;
  logic            w_valid;

  assign w_ins  = bus.inInstruction;
  assign w_fun3 = w_ins[14:12];
  assign w_fun7 = w_ins[31:25];

  // RV64 uses a 6-bit shamt, so only instruction[31:26] is the function field.
  assign w_shamt_ok = (XLEN == 64) ?
                      (w_ins[31:26] == 6'b000000 || w_ins[31:26] == 6'b010000) :
                      (w_fun7 == 7'b0000000 || w_fun7 == 7'b0100000);

  always_comb begin
    w_illegal   = 1'b0;
    w_alu       = AluAdd;
    w_imm       = '0;
    w_reg_write = 1'b0;
    w_en_alu    = 1'b0;
    w_use_imm   = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_load      = 1'b0;
    w_store     = 1'b0;
    case (w_ins[6:0])
      OpLui: begin
        w_imm       = XLEN'($signed({w_ins[31:12], 12'h000}));
        w_alu       = AluPassB;
        w_reg_write = 1'b1;
        w_en_alu    = 1'b1;
        w_use_imm   = 1'b1;
      end
      OpAuipc: begin
        w_imm       = XLEN'($signed({w_ins[31:12], 12'h000}));
        w_reg_write = 1'b1;
        w_en_alu    = 1'b1;
        w_use_imm   = 1'b1;
      end
      OpJal: begin
        w_imm       = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}));
        w_reg_write = 1'b1;
        w_use_imm   = 1'b1;
        w_jump      = 1'b1;
      end
      OpJalr: begin
        w_illegal   = (w_fun3 != 3'b000);
        w_imm       = XLEN'($signed(w_ins[31:20]));
        w_reg_write = 1'b1;
        w_en_alu    = 1'b1;
        w_use_imm   = 1'b1;
        w_jump      = 1'b1;
      end
      OpBranch: begin
        w_imm    = XLEN'($signed({w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0}));
        w_en_alu = 1'b1;
        w_branch = 1'b1;
        case (w_fun3)
          3'b000, 3'b001: w_alu = AluSub;
          3'b100, 3'b101: w_alu = AluSlt;
          3'b110, 3'b111: w_alu = AluSltu;
          default:        w_illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        w_illegal   = (XLEN == 64) ? (w_fun3 == 3'b111) :
                      (w_fun3 == 3'b011 || w_fun3 == 3'b110 || w_fun3 == 3'b111);
        w_imm       = XLEN'($signed(w_ins[31:20]));
        w_reg_write = 1'b1;
        w_en_alu    = 1'b1;
        w_use_imm   = 1'b1;
        w_load      = 1'b1;
      end
      OpStore: begin
        w_illegal = (XLEN == 64) ? (w_fun3 > 3'b011) : (w_fun3 > 3'b010);
        w_imm     = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
        w_en_alu  = 1'b1;
        w_use_imm = 1'b1;
        w_store   = 1'b1;
      end
      OpImm: begin
        w_imm       = XLEN'($signed(w_ins[31:20]));
        w_reg_write = 1'b1;
        w_en_alu    = 1'b1;
        w_use_imm   = 1'b1;
        case (w_fun3)
          3'b000: w_alu = AluAdd;
          3'b010: w_alu = AluSlt;
          3'b011: w_alu = AluSltu;
          3'b100: w_alu = AluXor;
          3'b110: w_alu = AluOr;
          3'b111: w_alu = AluAnd;
          3'b001: begin
            w_alu     = AluSll;
            w_illegal = !w_shamt_ok;
          end
          default: begin
            w_alu     = w_ins[30] ? AluSra : AluSrl;
            w_illegal = !w_shamt_ok;
          end
        endcase
      end
      OpReg: begin
        w_reg_write = 1'b1;
        w_en_alu    = 1'b1;
        if (w_fun7 == 7'b0000000) begin
          case (w_fun3)
            3'b000:  w_alu = AluAdd;
            3'b001:  w_alu = AluSll;
            3'b010:  w_alu = AluSlt;
            3'b011:  w_alu = AluSltu;
            3'b100:  w_alu = AluXor;
            3'b101:  w_alu = AluSrl;
            3'b110:  w_alu = AluOr;
            default: w_alu = AluAnd;
          endcase
        end else if (w_fun7 == 7'b0100000 && w_fun3 == 3'b000) begin
          w_alu = AluSub;
        end else if (w_fun7 == 7'b0100000 && w_fun3 == 3'b101) begin
          w_alu = AluSra;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Illegal encodings keep their raw fields but carry no immediate, ALU op or
  // control flags, so execute cannot act on a half-decoded instruction.
  always_comb begin
    w_dec           = '0;
    w_dec.pc        = bus.inPC;
    w_dec.opcode    = w_ins[6:0];
    w_dec.rd        = w_ins[11:7];
    w_dec.fun3      = w_fun3;
    w_dec.rs1       = w_ins[19:15];
    w_dec.rs2       = w_ins[24:20];
    w_dec.fun7      = w_fun7;
    w_dec.illegal   = w_illegal;
    w_dec.vi        = !w_illegal;
    if (!w_illegal) begin
      w_dec.imm       = w_imm;
      w_dec.alu       = w_alu;
      w_dec.reg_write = w_reg_write;
      w_dec.en_alu    = w_en_alu;
      w_dec.use_imm   = w_use_imm;
      w_dec.branch    = w_branch;
      w_dec.jump      = w_jump;
      w_dec.load      = w_load;
      w_dec.store     = w_store;
    end
  end

  // No full bypass: a full queue refuses a push even when it pops that cycle.
  assign w_ready = (r_count != CntW'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_push  = bus.inValid & w_ready;
  assign w_pop   = w_valid & bus.outReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= w_dec;
          r_wr_ptr        <= r_wr_ptr + PtrW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PtrW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CntW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CntW'(1);
        end
      end
      // Counts accepted illegal instructions even when a flush discards them.
      if (w_push && w_dec.illegal && (r_illegal_cnt != {CNTW{1'b1}})) begin
        r_illegal_cnt <= r_illegal_cnt + CNTW'(1);
      end
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.inReady        = w_ready;
  assign bus.outValid       = w_valid;
  assign bus.outPC          = w_head.pc;
  assign bus.opcode         = w_head.opcode;
  assign bus.rd             = w_head.rd;
  assign bus.fun3           = w_head.fun3;
  assign bus.rs1            = w_head.rs1;
  assign bus.rs2            = w_head.rs2;
  assign bus.fun7           = w_head.fun7;
  assign bus.immediateValue = w_head.imm;
  assign bus.opALU          = w_head.alu;
  assign bus.enRegWrite     = w_head.reg_write;
  assign bus.enALU          = w_head.en_alu;
  assign bus.useImmediate   = w_head.use_imm;
  assign bus.isBranch       = w_head.branch;
  assign bus.isJump         = w_head.jump;
  assign bus.isLoad         = w_head.load;
  assign bus.isStore        = w_head.store;
  assign bus.isVI           = w_head.vi;
  assign bus.isIllegal      = w_head.illegal;

  assign count        = r_count;
  assign illegalCount = r_illegal_cnt;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a 32-bit instance checked through a scoreboard of
// hand-computed expected bundles plus direct checks, and a 64-bit instance
// exercising RV64 shift and immediate width.
module tb_decode_queue;
  logic        clk;
  logic        rstN;
  logic        flush;
  logic        flush64;
  logic [2:0]  count;
  logic [15:0] ill_cnt;
  logic [2:0]  count64;
  logic [15:0] ill_cnt64;

  int checks   = 0;
  int failures = 0;

  // Flag order: enRegWrite enALU useImmediate isBranch isJump isLoad isStore isVI isIllegal
  localparam logic [8:0] FlImmAlu = 9'b111_0000_10;
  localparam logic [8:0] FlBranch = 9'b010_1000_10;
  localparam logic [8:0] FlJal    = 9'b101_0100_10;
  localparam logic [8:0] FlIll    = 9'b000_0000_01;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        alu_chk;
    logic [8:0]  flags;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  exp_t mon_e;
  logic [8:0] mon_flags;

  decode_queue_if #(.XLEN(32)) b32 ();
  decode_queue_if #(.XLEN(64)) b64 ();

  decode_queue #(.XLEN(32), .DEPTH(4), .CNTW(16)) dut (
    .clk(clk), .rstN(rstN), .flush(flush), .bus(b32), .count(count), .illegalCount(ill_cnt)
  );

  decode_queue #(.XLEN(64), .DEPTH(4), .CNTW(16)) dut64 (
    .clk(clk), .rstN(rstN), .flush(flush64), .bus(b64), .count(count64),
    .illegalCount(ill_cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [6:0] opc, input logic [4:0] rd,
                              input logic [3:0] alu, input logic alu_chk,
                              input logic [8:0] flags);
    exp_t e;
    e.pc = pc; e.imm = imm; e.opcode = opc; e.rd = rd;
    e.alu = alu; e.alu_chk = alu_chk; e.flags = flags;
    return e;
  endfunction

  // addi rd, x0, imm
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  // Scoreboard: record on accepted push, compare head on pop; flush drops all.
  always @(negedge clk) begin
    if (rstN) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (b32.outValid && b32.outReady) begin
          checks++;
          mon_flags = {b32.enRegWrite, b32.enALU, b32.useImmediate, b32.isBranch,
                       b32.isJump, b32.isLoad, b32.isStore, b32.isVI, b32.isIllegal};
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_pop_unexpected pc=%h", b32.outPC);
          end else begin
            mon_e = sb.pop_front();
            if (b32.outPC !== mon_e.pc || b32.immediateValue !== mon_e.imm ||
                b32.opcode !== mon_e.opcode || b32.rd !== mon_e.rd ||
                mon_flags !== mon_e.flags || (mon_e.alu_chk && b32.opALU !== mon_e.alu)) begin
              failures++;
              $display("FAIL sb_head got pc=%h imm=%h opc=%b rd=%0d alu=%b fl=%b exp pc=%h imm=%h opc=%b rd=%0d alu=%b fl=%b",
                       b32.outPC, b32.immediateValue, b32.opcode, b32.rd, b32.opALU, mon_flags,
                       mon_e.pc, mon_e.imm, mon_e.opcode, mon_e.rd, mon_e.alu, mon_e.flags);
            end
          end
        end
        if (b32.inValid && b32.inReady) sb.push_back(cur_exp);
      end
    end
  end

  task automatic push_one(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    b32.inValid = 1'b1; b32.inInstruction = ins; b32.inPC = pc; cur_exp = e;
    @(posedge clk); #1;
    b32.inValid = 1'b0;
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (b32.outValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b exp=0", b32.outValid); end
    checks++; if (b32.inReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", b32.inReady); end
    checks++; if (ill_cnt !== 16'd0) begin failures++; $display("FAIL reset_illcnt got=%0d exp=0", ill_cnt); end
    checks++; if (b32.immediateValue !== 32'd0 || b32.outPC !== 32'd0) begin
      failures++; $display("FAIL reset_data got imm=%h pc=%h exp 0", b32.immediateValue, b32.outPC);
    end
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi;
    b32.inValid = 1'b1; b32.inInstruction = 32'h00500093; b32.inPC = 32'h100;
    cur_exp = mk(32'h100, 32'd5, 7'b0010011, 5'd1, 4'b0000, 1'b1, FlImmAlu);
    #1;
    checks++; if (b32.outValid !== 1'b0) begin failures++; $display("FAIL addi_no_passthru got=%b exp=0", b32.outValid); end
    @(posedge clk); #1;
    b32.inValid = 1'b0;
    checks++; if (b32.outValid !== 1'b1) begin failures++; $display("FAIL addi_outvalid got=%b exp=1", b32.outValid); end
    checks++; if (b32.rd !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", b32.rd); end
    checks++; if (b32.immediateValue !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", b32.immediateValue); end
    checks++; if (b32.opALU !== 4'b0000) begin failures++; $display("FAIL addi_alu got=%b exp=0000", b32.opALU); end
    checks++; if (b32.useImmediate !== 1'b1) begin failures++; $display("FAIL addi_useimm got=%b exp=1", b32.useImmediate); end
    checks++; if (b32.outPC !== 32'h100) begin failures++; $display("FAIL addi_pc got=%h exp=100", b32.outPC); end
    b32.outReady = 1'b1;
    @(posedge clk); #1;
    b32.outReady = 1'b0;
    checks++; if (count !== 3'd0 || b32.outValid !== 1'b0) begin
      failures++; $display("FAIL addi_drain got count=%0d valid=%b exp 0 0", count, b32.outValid);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      push_one(addi(5'(i + 1), 12'(i + 10)), 32'h200 + 32'(4 * i),
               mk(32'h200 + 32'(4 * i), 32'(i + 10), 7'b0010011, 5'(i + 1), 4'b0000, 1'b1,
                  FlImmAlu));
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (b32.inReady !== 1'b0) begin failures++; $display("FAIL fill_inready got=%b exp=0", b32.inReady); end
    b32.inValid = 1'b1; b32.inInstruction = addi(5'd9, 12'd99); b32.inPC = 32'h2F0;
    cur_exp = mk(32'h2F0, 32'd99, 7'b0010011, 5'd9, 4'b0000, 1'b1, FlImmAlu);
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_holdoff got=%0d exp=4", count); end
    end
    b32.inValid = 1'b0;
    b32.outReady = 1'b1;
    for (int k = 0; k < 20 && count != 3'd0; k++) begin
      @(posedge clk); #1;
    end
    b32.outReady = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL fill_drain got=%0d exp=0", count); end
  endtask

  task automatic test_branch_jal;
    push_one(32'hFE000EE3, 32'h300,
             mk(32'h300, 32'hFFFFFFFC, 7'b1100011, 5'd29, 4'b0001, 1'b1, FlBranch));
    push_one(32'h800000EF, 32'h304,
             mk(32'h304, 32'hFFF00000, 7'b1101111, 5'd1, 4'b0000, 1'b1, FlJal));
    checks++; if (b32.isBranch !== 1'b1 || b32.immediateValue !== 32'hFFFFFFFC) begin
      failures++; $display("FAIL beq_head got br=%b imm=%h exp 1 fffffffc", b32.isBranch, b32.immediateValue);
    end
    b32.outReady = 1'b1;
    @(posedge clk); #1;
    checks++; if (b32.isJump !== 1'b1 || b32.immediateValue !== 32'hFFF00000) begin
      failures++; $display("FAIL jal_head got jmp=%b imm=%h exp 1 fff00000", b32.isJump, b32.immediateValue);
    end
    @(posedge clk); #1;
    b32.outReady = 1'b0;
  endtask

  task automatic test_lui_illegal;
    push_one(32'h12345037, 32'h400,
             mk(32'h400, 32'h12345000, 7'b0110111, 5'd0, 4'b1010, 1'b1, FlImmAlu));
    checks++; if (b32.immediateValue !== 32'h12345000 || b32.opALU !== 4'b1010) begin
      failures++; $display("FAIL lui_head got imm=%h alu=%b exp 12345000 1010", b32.immediateValue, b32.opALU);
    end
    push_one(32'h02000033, 32'h404, mk(32'h404, 32'd0, 7'b0110011, 5'd0, 4'b0000, 1'b0, FlIll));
    checks++; if (ill_cnt !== 16'd1) begin failures++; $display("FAIL illcnt_first got=%0d exp=1", ill_cnt); end
    // ld is not an RV32 load
    push_one(32'h00003083, 32'h408, mk(32'h408, 32'd0, 7'b0000011, 5'd1, 4'b0000, 1'b0, FlIll));
    checks++; if (ill_cnt !== 16'd2) begin failures++; $display("FAIL illcnt_second got=%0d exp=2", ill_cnt); end
    b32.outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b32.outReady = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL lui_drain got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back;
    push_one(addi(5'd3, 12'd30), 32'h500, mk(32'h500, 32'd30, 7'b0010011, 5'd3, 4'b0000, 1'b1, FlImmAlu));
    push_one(addi(5'd4, 12'hFFF), 32'h504,
             mk(32'h504, 32'hFFFFFFFF, 7'b0010011, 5'd4, 4'b0000, 1'b1, FlImmAlu));
    b32.outReady = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b32.inValid = 1'b1;
      b32.inInstruction = addi(5'(k + 5), 12'(k + 40));
      b32.inPC = 32'h508 + 32'(4 * k);
      cur_exp = mk(32'h508 + 32'(4 * k), 32'(k + 40), 7'b0010011, 5'(k + 5), 4'b0000, 1'b1,
                   FlImmAlu);
      @(posedge clk); #1;
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count k=%0d got=%0d exp=2", k, count); end
    end
    b32.inValid = 1'b0;
    b32.outReady = 1'b0;
    // Flush with an illegal push in the same cycle: queue empties, counter still counts.
    flush = 1'b1;
    b32.inValid = 1'b1; b32.inInstruction = 32'h02000033; b32.inPC = 32'h5F0;
    cur_exp = mk(32'h5F0, 32'd0, 7'b0110011, 5'd0, 4'b0000, 1'b0, FlIll);
    @(posedge clk); #1;
    flush = 1'b0;
    b32.inValid = 1'b0;
    checks++; if (count !== 3'd0 || b32.outValid !== 1'b0) begin
      failures++; $display("FAIL flush_empty got count=%0d valid=%b exp 0 0", count, b32.outValid);
    end
    checks++; if (b32.inReady !== 1'b1) begin failures++; $display("FAIL flush_inready got=%b exp=1", b32.inReady); end
    checks++; if (ill_cnt !== 16'd3) begin failures++; $display("FAIL flush_illcnt got=%0d exp=3", ill_cnt); end
  endtask

  task automatic test_xlen64;
    b64.inValid = 1'b1; b64.inInstruction = 32'h43F0D093; b64.inPC = 64'h8000_0000_0000_1000;
    @(posedge clk); #1;
    b64.inValid = 1'b0;
    checks++; if (b64.outValid !== 1'b1 || b64.opALU !== 4'b1001 || b64.isIllegal !== 1'b0) begin
      failures++; $display("FAIL srai64 got v=%b alu=%b ill=%b exp 1 1001 0", b64.outValid, b64.opALU, b64.isIllegal);
    end
    checks++; if (b64.immediateValue !== 64'h43F || b64.outPC !== 64'h8000_0000_0000_1000) begin
      failures++; $display("FAIL srai64_imm got imm=%h pc=%h exp 43f 8000000000001000", b64.immediateValue, b64.outPC);
    end
    b64.outReady = 1'b1;
    @(posedge clk); #1;
    b64.outReady = 1'b0;
    b64.inValid = 1'b1; b64.inInstruction = 32'hFFF00093; b64.inPC = 64'h1004;
    @(posedge clk); #1;
    b64.inInstruction = 32'h00003083; b64.inPC = 64'h1008;
    @(posedge clk); #1;
    b64.inValid = 1'b0;
    checks++; if (b64.immediateValue !== 64'hFFFF_FFFF_FFFF_FFFF || count64 !== 3'd2) begin
      failures++; $display("FAIL addi64_imm got imm=%h cnt=%0d exp ffffffffffffffff 2", b64.immediateValue, count64);
    end
    b64.outReady = 1'b1;
    @(posedge clk); #1;
    b64.outReady = 1'b0;
    checks++; if (b64.isLoad !== 1'b1 || b64.isIllegal !== 1'b0 || ill_cnt64 !== 16'd0) begin
      failures++; $display("FAIL ld64 got ld=%b ill=%b cnt=%0d exp 1 0 0", b64.isLoad, b64.isIllegal, ill_cnt64);
    end
  endtask

  initial begin
    rstN = 1'b0; flush = 1'b0; flush64 = 1'b0;
    b32.inValid = 1'b0; b32.inInstruction = '0; b32.inPC = '0; b32.outReady = 1'b0;
    b64.inValid = 1'b0; b64.inInstruction = '0; b64.inPC = '0; b64.outReady = 1'b0;
    cur_exp = mk(32'd0, 32'd0, 7'd0, 5'd0, 4'd0, 1'b0, 9'd0);
    test_reset();
    test_addi();
    test_fill();
    test_branch_jal();
    test_lui_illegal();
    test_back_to_back();
    test_xlen64();
    @(posedge clk); #1;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised, buffered instruction decode stage between fetch and execute. Accepts raw instructions with their PC over a valid/ready handshake, decodes them on entry (RV32I/RV64I base: R, I, load, store, branch, JAL, JALR, LUI, AUIPC), and holds up to DEPTH decoded bundles in a FIFO so fetch and execute can stall independently. It flags illegal encodings instead of defaulting them, supports a pipeline flush, and keeps a saturating illegal-instruction count.

## Interface
- XLEN, 32, datapath width; 32 or 64; sizes immediate and PC
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNTW, 16, illegal-counter width
- clk  in  1  clock, all state on rising edge
- rstN  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discard all queued entries
- inValid  in  1  fetch offers an instruction
- inReady  out  1  queue can accept (not full)
- inInstruction  in  32  raw instruction
- inPC  in  XLEN  instruction address
- outValid  out  1  head entry present
- outReady  in  1  execute consumes head
- outPC  out  XLEN  PC of head
- opcode/rd/fun3/rs1/rs2/fun7  out  7/5/3/5/5/7  fields of head
- immediateValue  out  XLEN  sign-extended immediate of head
- opALU  out  4  ALU op of head
- enRegWrite, enALU, useImmediate, isBranch, isJump, isLoad, isStore, isVI, isIllegal  out  1 each  head control flags
- count  out  $clog2(DEPTH)+1  occupied entries
- illegalCount  out  CNTW  saturating count of accepted illegal instructions

## Operation
- Push = inValid & inReady; pop = outValid & outReady. inReady = (count != DEPTH); no full-bypass (full with pop still refuses push).
- Decode is combinational on inInstruction; decoded bundle plus PC written into tail slot on push. Outputs are driven directly from head slot storage.
- Immediates, sign-extended from instruction[31] to XLEN: I (OP-IMM, JALR, LOAD) [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}; U {[31:12],12'b0}; R and illegal: 0.
- opALU: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010. LOAD/STORE/AUIPC/JALR -> ADD; LUI -> PASSB; branches: BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU; JAL 0000.
- Flags: enRegWrite for R, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC; enALU for all valid except JAL; useImmediate for all valid except R and branch; isJump JAL/JALR; isBranch branch opcode.
- Illegal: unknown opcode; R-type fun7 not 0000000 or (0100000 with fun3 000/101); branch fun3 010/011; load fun3 011/110/111 (XLEN=32) or 111 (XLEN=64); store fun3 > 010 (XLEN=32) or > 011 (XLEN=64); JALR fun3 != 0; shift-immediate upper bits invalid (XLEN=32: fun7 not 0000000/0100000; XLEN=64: instruction[31:26] not 000000/010000). Illegal entries: isIllegal=1, isVI=0, enRegWrite=enALU=isBranch=isJump=isLoad=isStore=0; still queued.
- Shifts: XLEN=64 shamt is instruction[25:20], SRAI selected by instruction[30].
- illegalCount increments on push of an illegal entry, saturates at all-ones, not cleared by flush.
- flush: count->0, pointers->0 next edge; overrides same-cycle push and pop; illegalCount still counts a same-cycle illegal push.

## Timing
- Reset (rstN low, async): count=0, outValid=0, inReady=1, pointers=0, all storage and data outputs 0, illegalCount=0.
- Latency: push at edge N -> outValid=1 with that bundle after edge N (visible cycle N+1). No same-cycle pass-through.
- Simultaneous push and pop: count unchanged; allowed at any count < DEPTH; at count=1 head advances to the new entry.
- Pointers wrap modulo DEPTH.
- outValid=0: data outputs hold stale head-slot contents; do not care.
- rstN asserted mid-stream: all entries lost immediately; inReady=1 while in reset.

## Test plan
- Reset, push 0x00500093 (addi x1,x0,5) PC 0x100, outReady=0 -> next cycle outValid=1, rd=1, immediateValue=5, opALU=0000, useImmediate=1, outPC=0x100.
- Push DEPTH instructions with outReady=0 -> count=4, inReady=0; fifth held off; assert outReady -> entries pop in order, count returns 0.
- Push 0xFE000EE3 (beq, imm -4) and 0x800000EF (jal) -> immediateValue 0xFFFFFFFC / 0xFFF00000, isBranch / isJump set.
- Push 0x12345037 (lui) -> immediateValue 0x12345000, opALU=1010; push 0x0200_0033 (fun7=0000001) -> isIllegal=1, isVI=0, illegalCount=1.
- Continuous push+pop at count=2 for 10 cycles -> count stays 2, order preserved across pointer wrap; flush with simultaneous push -> count=0, outValid=0 next cycle.
- XLEN=64: push 0x43F0D093 (srai shamt 63) -> opALU=1001, isIllegal=0; sign-extended immediate 64 bits wide.
